// File: rtl/pc_btb_if.sv
// pc_btb_if: fetch-side bundle for the pc_btb program counter / branch target buffer.
//   master : hazard unit + execute stage side (drives stall, redirect and predictor updates,
//            receives the fetch address and prediction)
//   slave  : the pc_btb block itself
// Signals:
//   pcenable              fetch advance (0 = stall)
//   redirect, redirect_pc execute-stage correction and the corrected fetch address
//   upd_valid, upd_pc,
//   upd_taken, upd_target resolved control-instruction outcome used to train the BTB
//   pcout                 current fetch address (registered)
//   pred_taken            prediction for the instruction at pcout
//   pred_target           predicted target for pcout, meaningful only when pred_taken=1
interface pc_btb_if #(
    parameter int WIDTH = 32
);
    logic             pcenable;
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic             upd_valid;
    logic [WIDTH-1:0] upd_pc;
    logic             upd_taken;
    logic [WIDTH-1:0] upd_target;
    logic [WIDTH-1:0] pcout;
    logic             pred_taken;
    logic [WIDTH-1:0] pred_target;

    modport master (
        output pcenable, redirect, redirect_pc,
        output upd_valid, upd_pc, upd_taken, upd_target,
        input  pcout, pred_taken, pred_target
    );

    modport slave (
        input  pcenable, redirect, redirect_pc,
        input  upd_valid, upd_pc, upd_taken, upd_target,
        output pcout, pred_taken, pred_target
    );
endinterface

// File: rtl/pc_btb.sv
// pc_btb: fetch-stage program counter with a direct-mapped branch target buffer and
// 2-bit saturating direction counters.
// Ports:
//   CLK  clock, all state updates on the rising edge
//   RST  asynchronous active-high reset (pcout <- RESET_PC, all entries invalid, ctr <- 01)
//   bus  pc_btb_if slave modport (stall/redirect/update in, pcout/prediction out)
// Next-PC priority: redirect > predicted-taken target > pcout+4 > hold.
// Lookup is combinational on pcout; an update written in cycle N is seen from cycle N+1.
module pc_btb #(
    parameter int               WIDTH     = 32,
    parameter int               BTB_DEPTH = 16,
    parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
    input  logic      CLK,
    input  logic      RST,
    pc_btb_if.slave   bus
);
    localparam int IDX   = $clog2(BTB_DEPTH);
    localparam int TAG_W = WIDTH - IDX - 2;
    localparam int TGT_W = WIDTH - 2;

    // Entry state. valid/ctr need reset so they live in flops; tag/target are never reset.
    logic [BTB_DEPTH-1:0] valid_reg;
    logic [BTB_DEPTH-1:0] valid_next;
    logic [1:0]           ctr_reg    [BTB_DEPTH];
    logic [1:0]           ctr_next   [BTB_DEPTH];
    logic [TAG_W-1:0]     tag_mem    [BTB_DEPTH];
    logic [TGT_W-1:0]     target_mem [BTB_DEPTH];

    logic [WIDTH-1:0]     pc_reg;
    logic [WIDTH-1:0]     pc_next;

    // Lookup on the current fetch address
    logic [IDX-1:0]       look_idx;
    logic                 look_hit;
    logic                 pred_taken_int;
    logic [WIDTH-1:0]     pred_target_int;

    assign look_idx        = pc_reg[IDX+1:2];
    assign look_hit        = valid_reg[look_idx] && (tag_mem[look_idx] == pc_reg[WIDTH-1:IDX+2]);
    assign pred_taken_int  = look_hit && ctr_reg[look_idx][1];
    assign pred_target_int = {target_mem[look_idx], 2'b00};

    // Update-side lookup (reads pre-update contents)
    logic [IDX-1:0]       upd_idx;
    logic [TAG_W-1:0]     upd_tag;
    logic                 upd_hit;

    assign upd_idx = bus.upd_pc[IDX+1:2];
    assign upd_tag = bus.upd_pc[WIDTH-1:IDX+2];
    assign upd_hit = valid_reg[upd_idx] && (tag_mem[upd_idx] == upd_tag);

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    // Per-entry next state: only the entry selected by upd_pc can change.
    for (genvar gi = 0; gi < BTB_DEPTH; gi++) begin : g_entry
        logic entry_upd;
        assign entry_upd = bus.upd_valid && (upd_idx == IDX'(gi));

        // Miss+taken allocates; hit+not-taken leaves the entry valid.
        assign valid_next[gi] = (entry_upd && bus.upd_taken) ? 1'b1 : valid_reg[gi];

        assign ctr_next[gi] = !entry_upd           ? ctr_reg[gi] :
                              upd_hit              ? (bus.upd_taken ? sat_inc(ctr_reg[gi])
                                                                    : sat_dec(ctr_reg[gi])) :
                              bus.upd_taken        ? 2'b10 :
                                                     ctr_reg[gi];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_reg <= '0;
            for (int i = 0; i < BTB_DEPTH; i++) begin
                ctr_reg[i] <= 2'b01;
            end
        end else begin
            valid_reg <= valid_next;
            for (int i = 0; i < BTB_DEPTH; i++) begin
                ctr_reg[i] <= ctr_next[i];
            end
        end
    end

    // Any taken update writes tag+target: on a hit the tag is unchanged, on a miss it allocates.
    always_ff @(posedge CLK) begin
        if (bus.upd_valid && bus.upd_taken) begin
            tag_mem[upd_idx]    <= upd_tag;
            target_mem[upd_idx] <= bus.upd_target[WIDTH-1:2];
        end
    end

    // Next fetch address; redirect overrides a stall.
    always_comb begin
        pc_next = pc_reg;
        if (bus.redirect) begin
            pc_next = {bus.redirect_pc[WIDTH-1:2], 2'b00};
        end else if (bus.pcenable && pred_taken_int) begin
            pc_next = pred_target_int;
        end else if (bus.pcenable) begin
            pc_next = pc_reg + WIDTH'(4);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign bus.pcout       = pc_reg;
    assign bus.pred_taken  = pred_taken_int;
    assign bus.pred_target = pred_target_int;
endmodule

// File: tb/tb_pc_btb.sv
// tb_pc_btb: directed testbench for pc_btb (WIDTH=32, BTB_DEPTH=16, RESET_PC=0x100).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_pc_btb;
    logic clk;
    logic rst;
    int   check_cnt;
    int   error_cnt;

    pc_btb_if #(.WIDTH(32)) bus ();

    pc_btb #(
        .WIDTH    (32),
        .BTB_DEPTH(16),
        .RESET_PC (32'h100)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            error_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = pc;
        bus.upd_taken  = taken;
        bus.upd_target = tgt;
        step();
        bus.upd_valid  = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        bus.redirect    = 1'b1;
        bus.redirect_pc = pc;
        step();
        bus.redirect    = 1'b0;
    endtask

    initial begin
        check_cnt       = 0;
        error_cnt       = 0;
        rst             = 1'b1;
        bus.pcenable    = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.upd_valid   = 1'b0;
        bus.upd_pc      = '0;
        bus.upd_taken   = 1'b0;
        bus.upd_target  = '0;

        #3;
        check("reset_pc", bus.pcout, 32'h100);
        check("reset_pred", 32'(bus.pred_taken), 32'h0);
        step();
        rst = 1'b0;

        // Sequential fetch
        check("seq0", bus.pcout, 32'h100);
        bus.pcenable = 1'b1;
        step(); check("seq1", bus.pcout, 32'h104); check("seq1_pred", 32'(bus.pred_taken), 32'h0);
        step(); check("seq2", bus.pcout, 32'h108); check("seq2_pred", 32'(bus.pred_taken), 32'h0);
        step(); check("seq3", bus.pcout, 32'h10C); check("seq3_pred", 32'(bus.pred_taken), 32'h0);

        // Allocate 0x104 -> 0x200 while stalled
        bus.pcenable = 1'b0;
        do_update(32'h104, 1'b1, 32'h200);
        check("stall_hold", bus.pcout, 32'h10C);
        do_redirect(32'h104);
        check("alloc_pc", bus.pcout, 32'h104);
        check("alloc_pred", 32'(bus.pred_taken), 32'h1);
        check("alloc_tgt", bus.pred_target, 32'h200);
        bus.pcenable = 1'b1;
        step();
        check("follow_pred", bus.pcout, 32'h200);

        // Counter hysteresis: 10 -> 01 -> 00
        bus.pcenable = 1'b0;
        do_update(32'h104, 1'b0, 32'h0);
        do_update(32'h104, 1'b0, 32'h0);
        do_redirect(32'h104);
        check("ctr00_pred", 32'(bus.pred_taken), 32'h0);
        do_update(32'h104, 1'b1, 32'h200);          // 00 -> 01
        check("ctr01_pred", 32'(bus.pred_taken), 32'h0);
        // Fetch and update in the same cycle: fetch uses the old (01) counter
        bus.pcenable = 1'b1;
        do_update(32'h104, 1'b1, 32'h200);          // 01 -> 10
        check("no_bypass_pc", bus.pcout, 32'h108);
        bus.pcenable = 1'b0;
        do_redirect(32'h104);
        check("ctr10_pred", 32'(bus.pred_taken), 32'h1);
        do_update(32'h104, 1'b1, 32'h240);          // 10 -> 11, new target
        check("ctr11_pred", 32'(bus.pred_taken), 32'h1);
        check("ctr11_tgt", bus.pred_target, 32'h240);
        do_update(32'h104, 1'b0, 32'h0);            // 11 -> 10, still taken
        check("hyst_pred", 32'(bus.pred_taken), 32'h1);
        check("hyst_tgt", bus.pred_target, 32'h240);

        // Redirect during stall, low bits dropped
        do_redirect(32'h3F7);
        check("redir_stall", bus.pcout, 32'h3F4);
        step();
        check("redir_hold", bus.pcout, 32'h3F4);

        // Aliasing: 0x144 shares index 1 with 0x104
        do_update(32'h144, 1'b1, 32'h300);
        do_redirect(32'h104);
        check("alias_evict", 32'(bus.pred_taken), 32'h0);
        do_redirect(32'h144);
        check("alias_pred", 32'(bus.pred_taken), 32'h1);
        check("alias_tgt", bus.pred_target, 32'h300);
        do_update(32'h184, 1'b0, 32'h0);
        check("miss_nt_keep", 32'(bus.pred_taken), 32'h1);
        check("miss_nt_tgt", bus.pred_target, 32'h300);
        bus.pcenable = 1'b1;
        step();
        check("alias_follow", bus.pcout, 32'h300);

        // Wrap-around
        bus.pcenable = 1'b0;
        do_redirect(32'hFFFF_FFFC);
        check("wrap_pre", bus.pcout, 32'hFFFF_FFFC);
        bus.pcenable = 1'b1;
        step();
        check("wrap", bus.pcout, 32'h0);

        // Asynchronous reset between edges, from a predicted-taken fetch address
        bus.pcenable = 1'b0;
        do_redirect(32'h144);
        check("pre_rst_pred", 32'(bus.pred_taken), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_pc", bus.pcout, 32'h100);
        check("async_rst_pred", 32'(bus.pred_taken), 32'h0);
        step();
        rst = 1'b0;
        bus.pcenable = 1'b1;
        step();
        check("post_rst_pc", bus.pcout, 32'h104);
        check("post_rst_pred", 32'(bus.pred_taken), 32'h0);
        step();
        check("post_rst_seq", bus.pcout, 32'h108);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end
endmodule
